// File: rtl/prog_seq_ctrl.sv
// prog_seq_ctrl: run-control and fetch sequencer for the 9-bit-ISA core family.
// Start is sampled as a level on Clk (never used as a clock). A Start rise
// arms the block and captures ProgSel; the following fall launches the
// program at its entry address. A fetched DONE_INSTR ends the run and raises
// Ack until the next Start rise.
// Optional: define PROG_SEQ_WATCHDOG_EN to end a run that reaches WDOG_LIMIT
// RUN cycles without a done instruction (Ack=1, Timeout=1).
module prog_seq_ctrl #(
    parameter int                PC_W       = 10,
    parameter int                INSTR_W    = 9,
    parameter int                NUM_PROGS  = 3,
    parameter int                SEL_W      = 2,
    parameter int                TGT_W      = 8,
    parameter int                TGT_SHIFT  = 2,
    parameter logic [INSTR_W-1:0] DONE_INSTR = '1,
    parameter int                CYC_W      = 16,
    parameter logic [31:0]       WDOG_LIMIT = 32'h0000_FFF0
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      Start,
    input  logic [SEL_W-1:0]          ProgSel,
    input  logic [NUM_PROGS*PC_W-1:0] ProgBase,
    input  logic [INSTR_W-1:0]        Instruction,
    input  logic                      BranchEn,
    input  logic                      ZeroFlag,
    input  logic [TGT_W-1:0]          Target,
    output logic [PC_W-1:0]           ProgCtr,
    output logic                      Go,
    output logic                      Ack,
    output logic [CYC_W-1:0]          CycleCount,
    output logic                      Timeout
);

    localparam int                TW       = TGT_W + TGT_SHIFT;
    localparam logic [SEL_W:0]    NP       = (SEL_W+1)'(NUM_PROGS);
    localparam logic [CYC_W-1:0]  WDOG_CMP = WDOG_LIMIT[CYC_W-1:0];
`ifdef PROG_SEQ_WATCHDOG_EN
    localparam logic              WDOG_ON  = 1'b1;
`else
    localparam logic              WDOG_ON  = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DONE} state_t;

    state_t             r_state;
    logic               r_start_q;
    logic               r_smp_vld;   // Start_q holds a real post-reset sample
    logic [SEL_W-1:0]   r_sel;
    logic [PC_W-1:0]    r_pc;
    logic               r_go;
    logic               r_ack;
    logic               r_to;
    logic [CYC_W-1:0]   r_cnt;

    logic               w_rise;
    logic               w_fall;
    logic [SEL_W-1:0]   w_sel_cap;
    logic [PC_W-1:0]    w_base;
    logic [TW-1:0]      w_tgt_wide;
    logic [PC_W-1:0]    w_tgt_pc;
    logic [PC_W-1:0]    w_pc_inc;
    logic [CYC_W-1:0]   w_cnt_nxt;
    logic               w_done;
    logic               w_wdog;

    // Gating with r_smp_vld keeps a Start held high through reset release
    // from looking like a rise.
    assign w_rise     = r_smp_vld &  Start & ~r_start_q;
    assign w_fall     = r_smp_vld & ~Start &  r_start_q;
    assign w_sel_cap  = ({1'b0, ProgSel} < NP) ? ProgSel : '0;
    assign w_tgt_wide = TW'(Target) << TGT_SHIFT;
    assign w_tgt_pc   = PC_W'(w_tgt_wide);
    assign w_pc_inc   = r_pc + 1'b1;
    assign w_cnt_nxt  = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    assign w_done     = (Instruction == DONE_INSTR);
    assign w_wdog     = WDOG_ON & (r_cnt == WDOG_CMP);

    // Entry-address mux over the flattened ProgBase bus
    always_comb begin
        w_base = ProgBase[PC_W-1:0];
        for (int k = 0; k < NUM_PROGS; k++) begin
            if (r_sel == SEL_W'(k)) w_base = ProgBase[k*PC_W +: PC_W];
        end
    end

    // Run-control FSM with registered outputs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= S_IDLE;
            r_start_q <= 1'b0;
            r_smp_vld <= 1'b0;
            r_sel     <= '0;
            r_pc      <= '0;
            r_go      <= 1'b0;
            r_ack     <= 1'b0;
            r_to      <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_start_q <= Start;
            r_smp_vld <= 1'b1;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_rise) begin
                        r_sel   <= w_sel_cap;
                        r_ack   <= 1'b0;
                        r_state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (w_fall) begin
                        r_pc    <= w_base;
                        r_cnt   <= '0;
                        r_to    <= 1'b0;
                        r_go    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_cnt <= w_cnt_nxt;
                    if (w_done) begin
                        // done beats a simultaneous branch; PC stays on it
                        r_go    <= 1'b0;
                        r_ack   <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_wdog) begin
                        r_go    <= 1'b0;
                        r_ack   <= 1'b1;
                        r_to    <= 1'b1;
                        r_state <= S_DONE;
                    end else if (BranchEn & ZeroFlag) begin
                        r_pc <= w_tgt_pc;
                    end else begin
                        r_pc <= w_pc_inc;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ProgCtr    = r_pc;
    assign Go         = r_go;
    assign Ack        = r_ack;
    assign CycleCount = r_cnt;
    assign Timeout    = r_to;

endmodule

// File: tb/tb_prog_seq_ctrl.sv
// Bench for prog_seq_ctrl: a behavioural model checked every clock and on
// async reset, plus directed runs with hand-computed literal expectations.
module tb_prog_seq_ctrl;

    localparam int WDOG = 20;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic [1:0]  ProgSel;
    logic [29:0] ProgBase;
    logic [8:0]  Instruction;
    logic        BranchEn;
    logic        ZeroFlag;
    logic [7:0]  Target;
    logic [9:0]  ProgCtr;
    logic        Go;
    logic        Ack;
    logic [15:0] CycleCount;
    logic        Timeout;

    logic [9:0]  done_addr;
    int          base_arr [3];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 Clk = ~Clk;

    // Instruction memory stand-in: the done encoding sits at done_addr only
    assign Instruction = (ProgCtr == done_addr) ? 9'h1FF : 9'h0A5;

    prog_seq_ctrl #(.WDOG_LIMIT(32'(WDOG))) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .ProgSel(ProgSel),
        .ProgBase(ProgBase), .Instruction(Instruction), .BranchEn(BranchEn),
        .ZeroFlag(ZeroFlag), .Target(Target), .ProgCtr(ProgCtr), .Go(Go),
        .Ack(Ack), .CycleCount(CycleCount), .Timeout(Timeout)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_go, m_ack, m_to, m_armed, m_seen, m_sprev, m_rise, m_fall;
    int m_pc, m_cnt, m_sel, m_old;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_go = 0; m_ack = 0; m_to = 0; m_armed = 0; m_seen = 0; m_sprev = 0;
            m_pc = 0; m_cnt = 0; m_sel = 0;
        end else begin
            m_rise = m_seen && Start && !m_sprev;
            m_fall = m_seen && !Start && m_sprev;
            if (m_go) begin
                m_old = m_cnt;
                m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
                if (m_pc == int'(done_addr)) begin
                    m_go = 0; m_ack = 1;
                end
`ifdef PROG_SEQ_WATCHDOG_EN
                else if (m_old == WDOG) begin
                    m_go = 0; m_ack = 1; m_to = 1;
                end
`endif
                else if (BranchEn && ZeroFlag) m_pc = (int'(Target) * 4) % 1024;
                else m_pc = (m_pc + 1) % 1024;
            end else if (m_armed) begin
                if (m_fall) begin
                    m_armed = 0; m_go = 1; m_pc = base_arr[m_sel]; m_cnt = 0; m_to = 0;
                end
            end else if (m_rise) begin
                m_armed = 1; m_ack = 0;
                m_sel = (int'(ProgSel) < 3) ? int'(ProgSel) : 0;
            end
            m_sprev = Start;
            m_seen  = 1;
        end
        #1;
        chk("m_ProgCtr", ProgCtr, m_pc);
        chk("m_Go", Go, m_go);
        chk("m_Ack", Ack, m_ack);
        chk("m_CycleCount", CycleCount, m_cnt);
        chk("m_Timeout", Timeout, m_to);
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_bases(input logic [9:0] b0, input logic [9:0] b1, input logic [9:0] b2);
        base_arr[0] = int'(b0); base_arr[1] = int'(b1); base_arr[2] = int'(b2);
        ProgBase = {b2, b1, b0};
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // One-cycle Start pulse; returns after the first RUN edge
    task automatic pulse(input logic [1:0] sel);
        @(negedge Clk); ProgSel = sel; Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        @(negedge Clk);
    endtask

    task automatic wait_pc(input logic [9:0] pc, input string nm);
        for (int i = 0; i < 64 && ProgCtr !== pc; i++) @(negedge Clk);
        chk(nm, ProgCtr, pc);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        Reset_n = 0; Start = 0; ProgSel = 0; BranchEn = 0; ZeroFlag = 0; Target = 0;
        done_addr = 10'h107;
        set_bases(10'h000, 10'h100, 10'h200);

        // Start toggles while held in reset
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk); Start = ~Start;
        end
        chk("rst_pc", ProgCtr, 0);
        chk("rst_go", Go, 0);
        chk("rst_cnt", CycleCount, 0);

        // Release with Start high: no rise, stays idle
        @(negedge Clk); Reset_n = 1;
        cyc(3);
        chk("rel_hi_go", Go, 0);
        Start = 0;
        cyc(2);
        chk("rel_lo_go", Go, 0);

        // Program 1, done at 0x107 with a simultaneous taken branch
        pulse(2'd1);
        chk("p1_first_fetch", ProgCtr, 10'h100);
        chk("p1_go", Go, 1);
        wait_pc(10'h107, "p1_reach_107");
        BranchEn = 1; ZeroFlag = 1; Target = 8'h05;
        @(negedge Clk);
        chk("p1_ack", Ack, 1);
        chk("p1_pc_hold", ProgCtr, 10'h107);
        chk("p1_cnt8", CycleCount, 8);
        chk("p1_go_low", Go, 0);
        BranchEn = 0; ZeroFlag = 0;
        cyc(3);
        chk("p1_ack_hold", Ack, 1);

        // Out-of-range select falls back to program 0; branches
        done_addr = 10'h020;
        pulse(2'd3);
        chk("sel3_fetch", ProgCtr, 10'h000);
        chk("sel3_ack_clr", Ack, 0);
        BranchEn = 1; ZeroFlag = 1; Target = 8'h05;
        @(negedge Clk);
        chk("br_taken", ProgCtr, 10'h014);
        ZeroFlag = 0;
        @(negedge Clk);
        chk("br_not_taken", ProgCtr, 10'h015);
        BranchEn = 0;
        wait_pc(10'h020, "sel3_reach_20");
        @(negedge Clk);
        chk("sel3_ack", Ack, 1);

        // PC wrap from 0x3FE
        set_bases(10'h000, 10'h100, 10'h3FE);
        done_addr = 10'h002;
        pulse(2'd2);
        chk("wrap_3fe", ProgCtr, 10'h3FE);
        @(negedge Clk); chk("wrap_3ff", ProgCtr, 10'h3FF);
        @(negedge Clk); chk("wrap_000", ProgCtr, 10'h000);
        wait_pc(10'h002, "wrap_reach_002");
        @(negedge Clk);
        chk("wrap_ack", Ack, 1);

        // Async reset mid-run
        done_addr = 10'h3FD;
        pulse(2'd2);
        cyc(1);
        chk("mid_pc_pre", ProgCtr, 10'h3FF);
        #3 Reset_n = 0;
        #1;
        chk("mid_rst_pc", ProgCtr, 0);
        chk("mid_rst_go", Go, 0);
        chk("mid_rst_ack", Ack, 0);
        chk("mid_rst_cnt", CycleCount, 0);
        @(negedge Clk); Reset_n = 1;
        cyc(3);
        chk("post_rst_ack", Ack, 0);
        chk("post_rst_go", Go, 0);

        // Run with no done instruction
        done_addr = 10'h3FF;
        set_bases(10'h000, 10'h100, 10'h200);
        pulse(2'd0);
`ifdef PROG_SEQ_WATCHDOG_EN
        for (int i = 0; i < 40 && CycleCount !== 16'(WDOG); i++) @(negedge Clk);
        chk("wd_cnt", CycleCount, WDOG);
        @(negedge Clk);
        chk("wd_ack", Ack, 1);
        chk("wd_timeout", Timeout, 1);
        chk("wd_go", Go, 0);
`else
        cyc(30);
        chk("nowd_cnt30", CycleCount, 30);
        chk("nowd_ack", Ack, 0);
        chk("nowd_timeout", Timeout, 0);
        chk("nowd_go", Go, 1);
`endif
        cyc(1);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/prog_seq_ctrl.md
Name: prog_seq_ctrl

Overview:
- Parametrised run-control and fetch sequencer for the 9-bit-ISA core family.
- Replaces the ad-hoc negedge-Start "go" flop, the fixed program counter and the done comparator with one synchronous block.
- Supports NUM_PROGS selectable program entry points, a configurable branch-target shift, a done-instruction detector with an Ack handshake, and a saturating cycle counter.
- Sits between InstMem (drives its address) and the control decoder (Go gates all write enables).

Parameters:
- PC_W, 10: program counter width.
- INSTR_W, 9: instruction width.
- NUM_PROGS, 3: number of selectable programs; must be >= 1.
- SEL_W, 2: width of ProgSel; must be >= $clog2(NUM_PROGS), minimum 1.
- TGT_W, 8: branch target register width.
- TGT_SHIFT, 2: left shift applied to Target to form the branch PC.
- DONE_INSTR, all-ones INSTR_W: encoding that ends a program.
- CYC_W, 16: cycle counter width.
- WDOG_LIMIT, 16'hFFF0: watchdog threshold; used only with the optional feature.

Ports:
- Clk  in  1  clock; all state on posedge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  testbench start request; level input, sampled on Clk.
- ProgSel  in  SEL_W  program index; captured on the Start rising edge.
- ProgBase  in  NUM_PROGS*PC_W  flattened entry addresses; program k occupies bits [k*PC_W +: PC_W].
- Instruction  in  INSTR_W  current InstMem output.
- BranchEn  in  1  decoder branch request.
- ZeroFlag  in  1  ALU zero flag.
- Target  in  TGT_W  branch target register value.
- ProgCtr  out  PC_W  instruction address.
- Go  out  1  high only in RUN; the decoder forces all write enables low when Go=0.
- Ack  out  1  program-done flag.
- CycleCount  out  CYC_W  number of RUN cycles for the current program.
- Timeout  out  1  watchdog-terminated flag.

Behaviour:
- Reset (Reset_n=0, asynchronous): state=IDLE; ProgCtr=0, Go=0, Ack=0, CycleCount=0, Timeout=0; Start_q=0; captured selection=0. Reset asserted mid-RUN aborts immediately, with no Ack.
- Start edge detection: Start_q is a register; rise = Start & ~Start_q; fall = ~Start & Start_q. Start is never used as a clock.
- IDLE: on rise, capture ProgSel (if ProgSel >= NUM_PROGS, capture 0), go to ARMED.
- ARMED: ProgCtr holds; Ack=0. On fall, load ProgCtr with ProgBase[sel], clear CycleCount and Timeout, go to RUN. Go rises in the same edge, so the first RUN cycle fetches the base address.
- RUN: Go=1; CycleCount increments each cycle and saturates at all-ones. Evaluate in this priority order:
  1. Instruction==DONE_INSTR: go to DONE, Ack=1 next cycle, ProgCtr holds on the done address, CycleCount freezes. This takes priority over a simultaneous branch.
  2. BranchEn & ZeroFlag: ProgCtr = ({Target} << TGT_SHIFT), zero-extended or truncated to PC_W.
  3. Otherwise: ProgCtr = ProgCtr+1. The increment wraps from 2^PC_W-1 to 0 with no flag.
- DONE: Ack=1, Go=0, ProgCtr and CycleCount held. On rise, capture ProgSel and go to ARMED; Ack clears on that same edge.
- Start held high through reset release: no rise is seen (Start_q samples the level after release), so the block stays in IDLE until Start toggles low then high.
- A rise and a fall cannot both occur in one cycle; a Start pulse that is high for one cycle yields rise, then fall, giving a two-cycle IDLE→ARMED→RUN transition.
- Latency: Start fall to first fetch = 1 cycle; done instruction fetched to Ack=1 = 1 cycle.

Optional Feature:
- Macro: PROG_SEQ_WATCHDOG_EN.
- With the macro: in RUN, if CycleCount reaches WDOG_LIMIT (compared over the low CYC_W bits) without a done instruction, the next edge goes to DONE with Ack=1 and Timeout=1. Timeout clears on entry to RUN.
- Without the macro: Timeout is tied to 0 and RUN can last indefinitely; the counter still saturates.

Test Plan:
- Reset: Reset_n low with Start toggling → ProgCtr=0, Go=0, Ack=0, CycleCount=0 throughout. Release with Start=1 → stays IDLE until a fresh rise.
- Program select: ProgBase={10'h200,10'h100,10'h000}, ProgSel=1, Start pulse → first RUN fetch at ProgCtr=0x100, Go=1. ProgSel=3 → fetch at 0x000.
- Branch: in RUN, Target=8'h05, BranchEn=1, ZeroFlag=1 → next ProgCtr=0x014. With ZeroFlag=0 → ProgCtr+1.
- Done/Ack: DONE_INSTR fetched at PC 0x107 with BranchEn=1 → Ack=1 next cycle, ProgCtr stays 0x107, CycleCount=8. Ack holds until the next Start rise, then clears.
- Wrap and reset: run from base 0x3FE with no branches → PC 0x3FE, 0x3FF, 0x000. Reset_n=0 mid-RUN → all outputs 0 asynchronously, and no Ack.
- Watchdog (PROG_SEQ_WATCHDOG_EN, WDOG_LIMIT=20): program with no done instruction → Ack=1 and Timeout=1 one cycle after CycleCount=20. Without the macro → Timeout stays 0 and Ack stays 0.
